// File: rtl/sample_logger.sv
// sample_logger: CS-edge sample capture, power-of-two averaging and FIFO buffering
module sample_logger #(
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              CLK_50MHz,
  input  logic              RESET,
  input  logic              CS_in,
  input  logic [7:0]        Sample_word,
  input  logic              Enable,
  input  logic              Rd_en,
  input  logic              Overflow_clr,
  output logic [7:0]        Data_out,
  output logic              Data_valid,
  output logic              Empty,
  output logic              Full,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow
);
  localparam int AW = 8 + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PH  = PW'((1 << AVG_LOG2) - 1);

  logic              cs_s1_q, cs_s2_q, cs_h_q;
  logic [AW-1:0]     acc_q, acc_d, sum;
  logic [PW-1:0]     phase_q, phase_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q, ovf_q, ovf_d, dv_q;
  logic [7:0]        dout_q, push_val;
  logic [7:0]        mem_q [DEPTH];
  logic              strobe, cap, push, rd_acc, wr_acc;

  // Capture strobe, averaging datapath and FIFO accept/occupancy decisions
  always_comb begin
    strobe   = cs_s2_q & ~cs_h_q;
    cap      = strobe & Enable;
    sum      = acc_q + AW'(Sample_word);
    push_val = sum[AVG_LOG2 +: 8];
    push     = cap & (phase_q == LAST_PH);
    rd_acc   = Rd_en & ~empty_q;
    wr_acc   = push & ((count_q != FULL_CNT) | rd_acc);
    acc_d    = (!Enable || push) ? '0 : cap ? sum : acc_q;
    phase_d  = (!Enable || push) ? '0 : cap ? phase_q + PW'(1) : phase_q;
    count_d  = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    ovf_d    = (push & ~wr_acc) | (ovf_q & ~Overflow_clr);
  end

  // State registers; CS flops reset high so release never looks like a rising edge
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_h_q   <= 1'b1;
      acc_q    <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      cs_s1_q  <= CS_in;
      cs_s2_q  <= cs_s1_q;
      cs_h_q   <= cs_s2_q;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_q <= rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == FULL_CNT);
      ovf_q    <= ovf_d;
      dv_q     <= rd_acc;
      dout_q   <= rd_acc ? mem_q[rd_ptr_q] : dout_q;
    end
  end

  // FIFO storage; a write into the slot being read returns the old entry
  always_ff @(posedge CLK_50MHz) begin
    if (wr_acc) mem_q[wr_ptr_q] <= push_val;
  end

  assign Data_out   = dout_q;
  assign Data_valid = dv_q;
  assign Empty      = empty_q;
  assign Full       = full_q;
  assign Count      = count_q;
  assign Overflow   = ovf_q;
endmodule

// File: tb/tb_sample_logger.sv
// tb_sample_logger: directed checks of an averaging (AVG_LOG2=2) and a pass-through (AVG_LOG2=0) logger
module tb_sample_logger;
  logic       clk = 1'b0;
  logic       rst_n, cs, en;
  logic [7:0] word;
  logic       rd4, rd1, clr4, clr1;
  logic [7:0] dout4, dout1;
  logic       dv4, dv1, emp4, emp1, full4, full1, ovf4, ovf1;
  logic [4:0] cnt4, cnt1;
  int         n_chk = 0, n_pass = 0;

  always #10 clk = ~clk;

  sample_logger #(.AVG_LOG2(2), .DEPTH(16), .ADDR_W(4)) u_a4 (
    .CLK_50MHz(clk), .RESET(rst_n), .CS_in(cs), .Sample_word(word), .Enable(en),
    .Rd_en(rd4), .Overflow_clr(clr4), .Data_out(dout4), .Data_valid(dv4),
    .Empty(emp4), .Full(full4), .Count(cnt4), .Overflow(ovf4));

  sample_logger #(.AVG_LOG2(0), .DEPTH(16), .ADDR_W(4)) u_a1 (
    .CLK_50MHz(clk), .RESET(rst_n), .CS_in(cs), .Sample_word(word), .Enable(en),
    .Rd_en(rd1), .Overflow_clr(clr1), .Data_out(dout1), .Data_valid(dv1),
    .Empty(emp1), .Full(full1), .Count(cnt1), .Overflow(ovf1));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cs = 1'b1;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic frame(input logic [7:0] w);
    cs = 1'b0;
    repeat (3) tick;
    word = w;
    cs = 1'b1;
    repeat (5) tick;
  endtask

  // Frame whose capture edge coincides with a one-cycle pulse on rd1 or clr1
  task automatic frame_pulse(input logic [7:0] w, input bit do_rd, input bit do_clr);
    cs = 1'b0;
    repeat (3) tick;
    word = w;
    cs = 1'b1;
    repeat (2) tick;
    rd1 = do_rd;
    clr1 = do_clr;
    tick;
    rd1 = 1'b0;
    clr1 = 1'b0;
  endtask

  initial begin
    en = 1'b1; word = 8'h00; rd4 = 1'b0; rd1 = 1'b0; clr4 = 1'b0; clr1 = 1'b0;
    do_reset;
    repeat (4) tick;
    chk("rst_count", cnt4, 0);
    chk("rst_empty", emp4, 1);
    chk("rst_full", full4, 0);
    chk("rst_dout", dout4, 0);
    chk("rst_dv", dv4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_count_a1", cnt1, 0);

    frame(8'd10); frame(8'd20); frame(8'd30);
    chk("avg_partial_count", cnt4, 0);
    frame(8'd41);
    chk("avg_count", cnt4, 1);
    chk("avg_pass_count_a1", cnt1, 4);
    rd4 = 1'b1;
    tick;
    rd4 = 1'b0;
    chk("avg_dout", dout4, 25);
    chk("avg_dv", dv4, 1);
    chk("avg_empty", emp4, 1);
    tick;
    chk("avg_dv_pulse", dv4, 0);
    chk("avg_dout_hold", dout4, 25);
    rd4 = 1'b1;
    tick;
    rd4 = 1'b0;
    chk("rd_empty_dv", dv4, 0);

    do_reset;
    for (int i = 1; i <= 16; i++) frame(8'(i));
    chk("fill_full", full1, 1);
    chk("fill_count", cnt1, 16);
    chk("fill_ovf", ovf1, 0);
    frame(8'h11);
    chk("drop_ovf", ovf1, 1);
    chk("drop_count", cnt1, 16);
    rd1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk($sformatf("drain_%0d", i), dout1, i);
      chk($sformatf("drain_dv_%0d", i), dv1, 1);
    end
    rd1 = 1'b0;
    tick;
    chk("drain_empty", emp1, 1);
    chk("drain_dv_off", dv1, 0);
    chk("drain_dout_hold", dout1, 16);

    do_reset;
    for (int i = 0; i < 16; i++) frame(8'(8'h20 + i));
    chk("refill_full", full1, 1);
    frame_pulse(8'h30, 1'b1, 1'b0);
    chk("fullrd_dout", dout1, 8'h20);
    chk("fullrd_dv", dv1, 1);
    chk("fullrd_count", cnt1, 16);
    chk("fullrd_ovf", ovf1, 0);
    chk("fullrd_full", full1, 1);
    repeat (3) tick;
    frame_pulse(8'h31, 1'b0, 1'b0);
    chk("ovf_set", ovf1, 1);
    repeat (3) tick;
    frame_pulse(8'h32, 1'b0, 1'b1);
    chk("ovf_set_beats_clr", ovf1, 1);
    repeat (3) tick;
    clr1 = 1'b1;
    tick;
    clr1 = 1'b0;
    chk("ovf_clr", ovf1, 0);
    rd1 = 1'b1;
    tick;
    rd1 = 1'b0;
    chk("wrap_order", dout1, 8'h21);

    do_reset;
    frame(8'd50); frame(8'd60);
    en = 1'b0;
    repeat (2) tick;
    en = 1'b1;
    frame(8'd100); frame(8'd100); frame(8'd100);
    chk("en_partial_count", cnt4, 0);
    frame(8'd100);
    chk("en_count", cnt4, 1);
    rd4 = 1'b1;
    tick;
    rd4 = 1'b0;
    chk("en_dout", dout4, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sample_logger.md
Name: sample_logger

Overview:
Downstream stage of the MCP3002 SPI leader, running on the 50 MHz system clock. It detects each completed ADC conversion by watching the leader's chip-select line, then captures the 8-bit sample word. It averages a programmable power-of-two number of samples and buffers the averaged results in a FIFO. The logging/readout logic drains the FIFO through a read-enable/valid handshake.

Parameters:
AVG_LOG2, 2, log2 of samples per average (0 = pass-through, max 4)
DEPTH, 16, FIFO entries, power of two, >= 2
ADDR_W, 4, log2(DEPTH)

Ports:
CLK_50MHz  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset
CS_in  input  1  ADC chip select from SPI leader; asynchronous to this block
Sample_word  input  8  latest conversion from SPI leader; updates on the same ADC-clock edge CS rises
Enable  input  1  1 = accept samples; 0 = ignore captures and clear the averaging phase
Rd_en  input  1  read request from consumer
Overflow_clr  input  1  clears Overflow
Data_out  output  8  averaged sample read from FIFO
Data_valid  output  1  one-cycle pulse, Data_out valid
Empty  output  1  FIFO holds 0 entries
Full  output  1  FIFO holds DEPTH entries
Count  output  ADDR_W+1  current FIFO occupancy
Overflow  output  1  sticky, an average was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, CLK_50MHz. Reset is RESET, asynchronous, active-low; everything below is stated with that fixed.
- Reset values: Data_out=0, Data_valid=0, Empty=1, Full=0, Count=0, Overflow=0. Accumulator=0, phase=0, pointers=0. The CS synchroniser and edge flops reset to 1 (idle high), so no false edge follows reset release.
- Synchronisation: CS_in passes through a 2-flop synchroniser plus one history flop. A capture strobe fires when synced=1 and history=0, i.e. on the 3rd CLK_50MHz edge after CS_in rises.
- Sample_word is sampled directly on the strobe cycle, with no synchroniser. It is safe because it is stable for a full 16-ADC-clock frame, about 288 system clocks.
- Strobe with Enable=0: no effect.
- Averaging: accumulator is 8+AVG_LOG2 bits.
  - Each strobe adds Sample_word and increments phase.
  - When phase reaches 2^AVG_LOG2-1, the push value is (acc+Sample_word)>>AVG_LOG2, truncated. A push is requested the same cycle, and acc and phase clear to 0.
  - AVG_LOG2=0: every strobe pushes Sample_word unchanged.
  - Enable falling: acc and phase clear to 0 on the next edge; FIFO contents are retained.
- FIFO: circular buffer with wr_ptr/rd_ptr of ADDR_W bits, wrapping DEPTH-1 -> 0. Count is held explicitly.
  - Push accepted if Count<DEPTH, or if Count==DEPTH and a read is accepted the same cycle.
  - Push with Count==DEPTH and no read: data dropped, pointers unchanged, Overflow<=1.
  - Read accepted when Rd_en=1 and Empty=0. Data_out<=mem[rd_ptr] and Data_valid=1 on the next edge, so latency is 1 cycle. Data_out holds its value afterwards.
  - Rd_en while Empty=1: ignored, Data_valid stays 0. A push landing in the same cycle is not readable until the following cycle.
  - Simultaneous accepted push and read: Count unchanged.
  - Empty = (Count==0) and Full = (Count==DEPTH), both registered alongside Count.
- Overflow: set has priority over Overflow_clr when both occur in the same cycle.
- RESET asserted mid-frame or mid-average: all state is lost immediately and the partial average is discarded. After release, the first strobe needs a genuine CS_in low->high transition.

Test Plan:
- Reset held with CS_in=1, then released -> no strobe, Count=0, Empty=1, Data_out=0.
- AVG_LOG2=2: 4 CS frames with Sample_word 10,20,30,41 -> one push of 25 (101>>2), Count=1. Then Rd_en for 1 cycle -> next cycle Data_out=25, Data_valid=1 for exactly 1 cycle, Empty=1.
- AVG_LOG2=0, DEPTH=16: 17 frames of 0x01..0x11 with no reads -> Full=1 after 16, Overflow=1 after the 17th. Draining all 16 gives 0x01..0x10 in order; 0x11 is absent.
- Full FIFO with Rd_en asserted on the cycle a push arrives -> push accepted, Count stays 16, Overflow stays 0, oldest entry output.
- Enable low after 2 of 4 samples, then high with 4 frames of 100 -> a single push of 100; earlier partial sum discarded.
- Overflow set, then Overflow_clr pulsed in the same cycle as another dropped push -> Overflow remains 1. Overflow_clr alone next -> Overflow=0.
